// File: rtl/dct_pkg.sv
// Shared sizes and the read-side FSM encoding for the DCT transpose buffer.
package dct_pkg;

    localparam int DCT_N      = 8;
    localparam int DCT_DATA_W = 32;
    localparam int DCT_ROW_W  = DCT_N * DCT_DATA_W;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_LOAD = 2'd1,
        RD_SHOW = 2'd2
    } rd_state_e;

endpackage

// File: rtl/tbuf_bank.sv
// One N x N bank: whole-row write port, column-gather read port.
module tbuf_bank
    import dct_pkg::*;
#(
    parameter int N      = DCT_N,
    parameter int DATA_W = DCT_DATA_W
) (
    input  logic                   i_clk,
    input  logic                   i_we,
    input  logic [$clog2(N)-1:0]   i_waddr,
    input  logic [N*DATA_W-1:0]    i_wdata,
    input  logic [$clog2(N)-1:0]   i_col,
    output logic [N*DATA_W-1:0]    o_col
);

    logic [N*DATA_W-1:0] r_mem [N];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Lane i_col of row r lands in lane r of the gathered column.
    always_comb begin
        o_col = '0;
        for (int r = 0; r < N; r++) begin
            o_col[r*DATA_W +: DATA_W] = r_mem[r][int'(i_col)*DATA_W +: DATA_W];
        end
    end

endmodule

// File: rtl/dct_transpose_buf.sv
// Ping-pong 8x8 transpose buffer: rows in from the row-DCT pass, columns out to the column pass.
module dct_transpose_buf
    import dct_pkg::*;
#(
    parameter int DATA_W = DCT_DATA_W,
    parameter int N      = DCT_N
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*DATA_W-1:0] in_row,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N*DATA_W-1:0] out_col,
    output logic                blk_done,
    output logic                busy,
    output rd_state_e           o_dbg_rd_state
);

    localparam int            AW   = $clog2(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    logic                r_wr_bank;
    logic                r_rd_bank;
    logic [AW-1:0]       r_wr_row;
    logic [AW-1:0]       r_rd_col;
    logic [1:0]          r_full;
    rd_state_e           r_state;
    logic                r_out_valid;
    logic                r_blk_done;
    logic [N*DATA_W-1:0] r_out_col;

    rd_state_e           w_state_nxt;
    logic                w_wr_fire;
    logic                w_wr_last;
    logic                w_rd_fire;
    logic                w_rd_last;
    logic                w_other_full;
    logic                w_load;
    logic                w_clr_valid;
    logic                w_sel_bank;
    logic [AW-1:0]       w_sel_col;
    logic [N*DATA_W-1:0] w_col0;
    logic [N*DATA_W-1:0] w_col1;
    logic [N*DATA_W-1:0] w_gather;

    assign in_ready       = ~r_full[r_wr_bank];
    assign out_valid      = r_out_valid;
    assign out_col        = r_out_col;
    assign blk_done       = r_blk_done;
    assign busy           = (|r_full) | (r_wr_row != '0);
    assign o_dbg_rd_state = r_state;

    assign w_wr_fire    = in_valid & in_ready;
    assign w_wr_last    = w_wr_fire && (r_wr_row == LAST);
    assign w_rd_fire    = r_out_valid & out_ready & (r_state == RD_SHOW);
    assign w_rd_last    = w_rd_fire && (r_rd_col == LAST);
    assign w_other_full = r_full[~r_rd_bank];

    tbuf_bank #(.N(N), .DATA_W(DATA_W)) u_bank0 (
        .i_clk   (clk),
        .i_we    (w_wr_fire & ~r_wr_bank),
        .i_waddr (r_wr_row),
        .i_wdata (in_row),
        .i_col   (w_sel_col),
        .o_col   (w_col0)
    );

    tbuf_bank #(.N(N), .DATA_W(DATA_W)) u_bank1 (
        .i_clk   (clk),
        .i_we    (w_wr_fire & r_wr_bank),
        .i_waddr (r_wr_row),
        .i_wdata (in_row),
        .i_col   (w_sel_col),
        .o_col   (w_col1)
    );

    assign w_gather = w_sel_bank ? w_col1 : w_col0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RD_IDLE: if (r_full[r_rd_bank]) w_state_nxt = RD_LOAD;
            RD_LOAD: w_state_nxt = RD_SHOW;
            RD_SHOW: if (w_rd_last && !w_other_full) w_state_nxt = RD_IDLE;
            default: w_state_nxt = RD_IDLE;
        endcase
    end

    // A ready second bank is fetched on the last-column handshake itself, so blocks drain without a bubble.
    always_comb begin
        w_load      = 1'b0;
        w_clr_valid = 1'b0;
        w_sel_bank  = r_rd_bank;
        w_sel_col   = r_rd_col;
        case (r_state)
            RD_LOAD: w_load = 1'b1;
            RD_SHOW: begin
                if (w_rd_last) begin
                    if (w_other_full) begin
                        w_load     = 1'b1;
                        w_sel_bank = ~r_rd_bank;
                        w_sel_col  = '0;
                    end else begin
                        w_clr_valid = 1'b1;
                    end
                end else if (w_rd_fire) begin
                    w_load    = 1'b1;
                    w_sel_col = r_rd_col + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_bank <= 1'b0;
            r_wr_row  <= '0;
        end else if (w_wr_fire) begin
            if (w_wr_last) begin
                r_wr_row  <= '0;
                r_wr_bank <= ~r_wr_bank;
            end else begin
                r_wr_row <= r_wr_row + 1'b1;
            end
        end
    end

    // The clear is written last so a free wins over a fill of the same bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= '0;
        end else begin
            if (w_wr_last) r_full[r_wr_bank] <= 1'b1;
            if (w_rd_last) r_full[r_rd_bank] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_bank   <= 1'b0;
            r_rd_col    <= '0;
            r_out_valid <= 1'b0;
            r_out_col   <= '0;
            r_blk_done  <= 1'b0;
        end else begin
            r_blk_done <= w_rd_last;
            if (w_rd_last) begin
                r_rd_col  <= '0;
                r_rd_bank <= ~r_rd_bank;
            end else if (w_rd_fire) begin
                r_rd_col <= r_rd_col + 1'b1;
            end
            if (w_load) begin
                r_out_col   <= w_gather;
                r_out_valid <= 1'b1;
            end else if (w_clr_valid) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Self-checking bench: random rows in, columns checked against a golden transpose of each accepted block.
module tb_dct_transpose_buf;
    import dct_pkg::*;

    localparam int N  = DCT_N;
    localparam int W  = DCT_DATA_W;
    localparam int RW = DCT_ROW_W;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          in_valid  = 1'b0;
    logic [RW-1:0] in_row    = '0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [RW-1:0] out_col;
    logic          blk_done;
    logic          busy;
    rd_state_e     dbg_state;

    always #5 clk = ~clk;

    dct_transpose_buf #(.DATA_W(W), .N(N)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_row         (in_row),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_col        (out_col),
        .blk_done       (blk_done),
        .busy           (busy),
        .o_dbg_rd_state (dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] row_buf[$];
    int            col_pop      = 0;
    int            total_pops   = 0;
    int            done_cnt     = 0;
    logic          exp_done     = 1'b0;
    logic          stalled_prev = 1'b0;
    logic [RW-1:0] held_col     = '0;
    int            rdy_mode     = 0;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Inputs settle long before the negedge, so valid&ready here is exactly the next edge's transfer.
    always @(negedge clk) begin
        logic [RW-1:0] tcol;
        logic [RW-1:0] trow;
        if (rst) begin
            row_buf.delete();
            exp_q.delete();
            col_pop      = 0;
            exp_done     = 1'b0;
            stalled_prev = 1'b0;
        end else begin
            if (blk_done) done_cnt++;
            if (blk_done || exp_done) check("blk_done", RW'(blk_done), RW'(exp_done));
            exp_done = 1'b0;
            if (stalled_prev) begin
                check("hold_valid", RW'(out_valid), RW'(1'b1));
                check("hold_col", out_col, held_col);
            end
            stalled_prev = out_valid && !out_ready;
            held_col     = out_col;
            if (in_valid && in_ready) begin
                row_buf.push_back(in_row);
                if (row_buf.size() == N) begin
                    for (int c = 0; c < N; c++) begin
                        tcol = '0;
                        for (int r = 0; r < N; r++) begin
                            trow = row_buf[r];
                            tcol[r*W +: W] = trow[c*W +: W];
                        end
                        exp_q.push_back(tcol);
                    end
                    row_buf.delete();
                end
            end
            if (out_valid && out_ready) begin
                total_pops++;
                if (exp_q.size() == 0) begin
                    check("spurious_col", RW'(out_valid), RW'(1'b0));
                end else begin
                    check("col", out_col, exp_q.pop_front());
                    col_pop++;
                    if (col_pop == N) begin
                        col_pop  = 0;
                        exp_done = 1'b1;
                    end
                end
            end
        end
    end

    function automatic logic [RW-1:0] make_row(input int kind, input int r);
        logic [RW-1:0] v;
        v = '0;
        for (int c = 0; c < N; c++) begin
            case (kind)
                0:       v[c*W +: W] = W'(r * N + c);
                2:       v[c*W +: W] = ((r + c) % 2 == 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
                3:       v[c*W +: W] = ((r + c) % 2 == 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
                default: v[c*W +: W] = $urandom();
            endcase
        end
        return v;
    endfunction

    // Called and returns at posedge+1 phase.
    task automatic send_row(input logic [RW-1:0] row, input int gap_max);
        int   waited;
        logic done;
        if (gap_max > 0) begin
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_row   = row;
        waited   = 0;
        done     = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
            end else begin
                waited++;
                if (waited >= 500) begin
                    check("in_ready_timeout", RW'(in_ready), RW'(1'b1));
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_block(input int kind, input int gap_max);
        for (int r = 0; r < N; r++) send_row(make_row(kind, r), gap_max);
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", RW'(exp_q.size()), RW'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, errors=%0d", n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            d0;
        int            base;
        int            k;
        logic [RW-1:0] col0_exp;
        logic [RW-1:0] r17;

        rdy_mode = 1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", RW'(in_ready), RW'(1'b1));
        check("rst_out_valid", RW'(out_valid), RW'(1'b0));
        check("rst_out_col", out_col, RW'(0));
        check("rst_blk_done", RW'(blk_done), RW'(1'b0));
        check("rst_busy", RW'(busy), RW'(1'b0));
        check("rst_state", RW'(dbg_state), RW'(RD_IDLE));
        @(posedge clk);
        #1;

        // Single block with the r*8+c pattern, plus first-column latency.
        d0 = done_cnt;
        col0_exp = '0;
        for (int r = 0; r < N; r++) col0_exp[r*W +: W] = W'(r * N);
        for (int r = 0; r < N; r++) begin
            send_row(make_row(0, r), 0);
            if (r == 3) check("t1_busy_partial", RW'(busy), RW'(1'b1));
        end
        @(negedge clk);
        check("t1_lat_e1", RW'(out_valid), RW'(1'b0));
        @(negedge clk);
        check("t1_lat_e2", RW'(out_valid), RW'(1'b0));
        @(negedge clk);
        check("t1_lat_valid", RW'(out_valid), RW'(1'b1));
        check("t1_first_col", out_col, col0_exp);
        @(posedge clk);
        #1;
        wait_drain(200);
        check("t1_done_count", RW'(done_cnt - d0), RW'(1));
        check("t1_idle_busy", RW'(busy), RW'(1'b0));

        // Streaming: four blocks with both sides always willing.
        d0 = done_cnt;
        for (int b = 0; b < 4; b++) send_block(1, 0);
        wait_drain(300);
        check("t2_done_count", RW'(done_cnt - d0), RW'(4));

        // Backpressure after two columns; second bank fills, third block stalls.
        d0   = done_cnt;
        base = total_pops;
        send_block(1, 0);
        k = 0;
        while (total_pops < base + 2 && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        rdy_mode = 0;
        check("t3_two_cols", RW'(total_pops - base), RW'(2));
        @(posedge clk);
        #1;
        send_block(1, 0);
        check("t3_hold_col2", out_col, exp_q[0]);
        check("t3_busy_full", RW'(busy), RW'(1'b1));
        r17      = make_row(1, 0);
        in_valid = 1'b1;
        in_row   = r17;
        repeat (3) begin
            @(negedge clk);
            check("t3_in_ready_low", RW'(in_ready), RW'(1'b0));
        end
        repeat (7) @(posedge clk);
        #1;
        rdy_mode = 1;
        send_row(r17, 0);
        for (int r = 1; r < N; r++) send_row(make_row(1, r), 0);
        wait_drain(300);
        check("t3_done_count", RW'(done_cnt - d0), RW'(3));

        // Random valid/ready toggling over sixteen blocks.
        d0       = done_cnt;
        rdy_mode = 2;
        for (int b = 0; b < 16; b++) send_block(1, 2);
        rdy_mode = 1;
        wait_drain(2000);
        check("t4_done_count", RW'(done_cnt - d0), RW'(16));

        // Reset with a partial block written and a full block mid-drain.
        rdy_mode = 0;
        send_block(1, 0);
        for (int r = 0; r < 5; r++) send_row(make_row(1, r), 0);
        rdy_mode = 1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("t5_busy_pre", RW'(busy), RW'(1'b1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t5_in_ready", RW'(in_ready), RW'(1'b1));
        check("t5_out_valid", RW'(out_valid), RW'(1'b0));
        check("t5_out_col", out_col, RW'(0));
        check("t5_blk_done", RW'(blk_done), RW'(1'b0));
        check("t5_busy", RW'(busy), RW'(1'b0));

        // Extreme lane values after reset.
        d0 = done_cnt;
        send_block(2, 0);
        wait_drain(200);
        send_block(3, 0);
        wait_drain(200);
        check("t6_done_count", RW'(done_cnt - d0), RW'(2));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
